// File: rtl/router_pkg.sv
// Shared definitions for the router output port: header field positions,
// drain FSM state encoding and the default client-stall timeout.
package router_pkg;

   localparam int LEN_MSB  = 7;
   localparam int LEN_LSB  = 2;
   localparam int ADDR_MSB = 1;
   localparam int ADDR_LSB = 0;

   localparam int DEF_TIMEOUT = 30;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SEND = 2'd2
   } state_t;

endpackage

// File: rtl/router_out_timer.sv
// Stall counter for the output port: counts consecutive stalled cycles and
// flags the stalled cycle that brings the count up to TIMEOUT.
module router_out_timer #(
   parameter int TIMEOUT = 30
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   // the stalled cycle seeing TIMEOUT-1 is the one that completes the count
   assign expire = enable && (count == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear || expire) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/router_out_port.sv
// Drains one router FIFO byte-by-byte to a valid/ready client, re-framing packets
// from the header length field. Parity checking is built only with ROUTER_OUT_PARITY_CHK_EN.
module router_out_port import router_pkg::*; #(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int LEN_W   = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_read_enb,
   output logic       fifo_soft_reset,
   output logic [7:0] dest_data,
   output logic       dest_valid,
   input  logic       dest_ready,
   output logic       dest_sop,
   output logic       dest_eop,
   output logic       parity_err,
   output logic       pkt_drop,
   output logic       busy
);

   localparam int RW = LEN_W + 1;

   state_t        state;
   state_t        next_state;
   logic          in_pkt;
   logic [RW-1:0] remaining;
   logic          capture;
   logic          accept;
   logic          stall;
   logic          expire;

   assign capture = (state == REQ);
   assign accept  = (state == SEND) && dest_ready;
   assign stall   = (state == SEND) && !dest_ready;

   router_out_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (!stall),
      .enable (stall),
      .expire (expire)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // REQ always returns to SEND, so two reads are never back to back
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               next_state = REQ;
            end
         end
         REQ: begin
            next_state = SEND;
         end
         SEND: begin
            if (dest_ready) begin
               next_state = (!dest_eop && !fifo_empty) ? REQ : IDLE;
            end else if (expire) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_comb begin
      dest_valid = (state == SEND);
      busy       = in_pkt || (state != IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fifo_read_enb   <= 1'b0;
         fifo_soft_reset <= 1'b0;
         pkt_drop        <= 1'b0;
      end else begin
         fifo_read_enb   <= (next_state == REQ);
         fifo_soft_reset <= expire;
         pkt_drop        <= expire;
      end
   end

   // remaining counts payload bytes still owed plus the trailing parity byte
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         in_pkt    <= 1'b0;
         remaining <= '0;
         dest_data <= '0;
         dest_sop  <= 1'b0;
         dest_eop  <= 1'b0;
      end else begin
         if (capture) begin
            dest_data <= fifo_data;
            if (!in_pkt) begin
               in_pkt    <= 1'b1;
               remaining <= RW'(fifo_data[LEN_MSB:LEN_LSB]) + RW'(1);
               dest_sop  <= 1'b1;
               dest_eop  <= 1'b0;
            end else begin
               dest_sop  <= 1'b0;
               dest_eop  <= (remaining == RW'(1));
            end
         end
         if (accept) begin
            if (dest_eop) begin
               in_pkt <= 1'b0;
            end else if (!dest_sop) begin
               remaining <= remaining - RW'(1);
            end
         end
         if (expire) begin
            in_pkt <= 1'b0;
         end
      end
   end

`ifdef ROUTER_OUT_PARITY_CHK_EN
   logic [7:0] acc;

   // header seeds the accumulator; the parity byte itself is never folded in
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc        <= '0;
         parity_err <= 1'b0;
      end else begin
         parity_err <= accept && dest_eop && (dest_data != acc);
         if (capture) begin
            if (!in_pkt) begin
               acc <= fifo_data;
            end else if (remaining != RW'(1)) begin
               acc <= acc ^ fifo_data;
            end
         end
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_port.sv
// Self-checking bench for router_out_port: FIFO model, vector table, corner
// sequences and randomized packets checked against a packet-level model.
module tb_router_out_port;

`ifdef ROUTER_OUT_PARITY_CHK_EN
   localparam int PERR = 1;
`else
   localparam int PERR = 0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data = 8'h00;
   logic       fifo_read_enb;
   logic       fifo_soft_reset;
   logic [7:0] dest_data;
   logic       dest_valid;
   logic       dest_ready = 1'b0;
   logic       dest_sop;
   logic       dest_eop;
   logic       parity_err;
   logic       pkt_drop;
   logic       busy;

   router_out_port #(
      .TIMEOUT (30),
      .LEN_W   (6)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .fifo_empty      (fifo_empty),
      .fifo_data       (fifo_data),
      .fifo_read_enb   (fifo_read_enb),
      .fifo_soft_reset (fifo_soft_reset),
      .dest_data       (dest_data),
      .dest_valid      (dest_valid),
      .dest_ready      (dest_ready),
      .dest_sop        (dest_sop),
      .dest_eop        (dest_eop),
      .parity_err      (parity_err),
      .pkt_drop        (pkt_drop),
      .busy            (busy)
   );

   always #5 clock = ~clock;

   // FIFO model: data_out updates on the falling edge when read_enb is high
   logic [7:0] mem [0:8191];
   int wr_ptr = 0;
   int rd_ptr = 0;

   always @(negedge clock) begin
      int nxt;
      nxt = rd_ptr;
      if (reset || fifo_soft_reset) begin
         nxt = wr_ptr;
      end else if (fifo_read_enb && rd_ptr != wr_ptr) begin
         fifo_data <= mem[rd_ptr];
         nxt = rd_ptr + 1;
      end
      rd_ptr     <= nxt;
      fifo_empty <= (nxt == wr_ptr);
   end

   // transfer and pulse monitor
   logic [9:0] obs [0:8191];
   int obs_n  = 0;
   int n_perr = 0;
   int n_drop = 0;

   always @(negedge clock) begin
      if (!reset) begin
         if (dest_valid && dest_ready) begin
            obs[obs_n] <= {dest_sop, dest_eop, dest_data};
            obs_n      <= obs_n + 1;
         end
         if (parity_err) n_perr <= n_perr + 1;
         if (pkt_drop)   n_drop <= n_drop + 1;
      end
   end

   typedef struct {
      logic [7:0] hdr;
      logic [7:0] corrupt;
      int         stall_at;
      int         stall_len;
      int         exp_xfers;
      int         exp_err;
      int         exp_drop;
   } vec_t;

   vec_t       vecs [8];
   int         total = 0;
   int         bad   = 0;
   logic [9:0] exp_q [$];
   int         exp_err;
   int         base;
   int         perr0;
   int         drop0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] outs();
      return {fifo_read_enb, fifo_soft_reset, dest_data, dest_valid,
              dest_sop, dest_eop, parity_err, pkt_drop, busy};
   endfunction

   task automatic begin_run();
      exp_q.delete();
      exp_err = 0;
      base    = obs_n;
      perr0   = n_perr;
      drop0   = n_drop;
   endtask

   // Builds a packet, records what the client must see, then loads the FIFO.
   // split>0 pauses the FIFO feed before byte 'split' for 40 cycles.
   task automatic add_pkt(input logic [7:0] hdr, input logic [7:0] corrupt,
                          input bit rnd, input int split);
      logic [7:0] p [$];
      logic [7:0] x;
      logic [7:0] b;
      logic [7:0] xa;
      int         len;
      len = int'(hdr[7:2]);
      p.push_back(hdr);
      x = hdr;
      for (int i = 0; i < len; i++) begin
         b = rnd ? 8'($urandom) : 8'(8'h11 * (i + 1));
         p.push_back(b);
         x ^= b;
      end
      p.push_back(x ^ corrupt);
      xa = 8'h00;
      for (int i = 0; i < p.size(); i++) begin
         exp_q.push_back({(i == 0), (i == p.size() - 1), p[i]});
         xa ^= p[i];
      end
      if (xa != 8'h00) exp_err += PERR;
      for (int i = 0; i < p.size(); i++) begin
         if (split > 0 && i == split) begin
            dest_ready = 1'b1;
            repeat (40) @(posedge clock);
            #1;
            check("dry_wait_busy", 32'(busy), 32'd1);
            check("dry_wait_nodrop", n_drop - drop0, 0);
         end
         mem[wr_ptr] = p[i];
         wr_ptr++;
      end
   endtask

   task automatic drain(input int budget, input int stall_at, input int stall_len, input bit rnd);
      int scnt;
      bit done;
      scnt = 0;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(posedge clock);
         #1;
         if (!busy && rd_ptr == wr_ptr && fifo_empty) begin
            done = 1'b1;
         end else if (dest_valid && (obs_n - base) == stall_at && scnt < stall_len) begin
            dest_ready = 1'b0;
            scnt++;
         end else if (rnd) begin
            dest_ready = ($urandom_range(0, 3) != 0);
         end else begin
            dest_ready = 1'b1;
         end
      end
      check("drain_in_budget", 32'(done), 32'd1);
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic end_checks(input string tag, input int exp_x, input int e_err, input int e_drop);
      int nx;
      int mism;
      nx   = obs_n - base;
      mism = 0;
      for (int i = 0; i < nx && i < exp_q.size(); i++) begin
         if (obs[base + i] !== exp_q[i]) mism++;
      end
      check({tag, "_xfers"}, nx, exp_x);
      check({tag, "_content"}, mism, 0);
      check({tag, "_perr"}, n_perr - perr0, e_err);
      check({tag, "_drop"}, n_drop - drop0, e_drop);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1, "watchdog");
   end

   int         seen;
   int         cnt;
   logic [7:0] hdr;
   logic [7:0] corrupt;
   int         np;

   initial begin
      vecs[0] = '{8'h0D, 8'h00, -1,  0,  5, 0,    0};
      vecs[1] = '{8'h0D, 8'h01, -1,  0,  5, PERR, 0};
      vecs[2] = '{8'h02, 8'h00, -1,  0,  2, 0,    0};
      vecs[3] = '{8'h0D, 8'h00,  1, 10,  5, 0,    0};
      vecs[4] = '{8'h0D, 8'h00,  1, 29,  5, 0,    0};
      vecs[5] = '{8'h0D, 8'h00,  1, 40,  1, 0,    1};
      vecs[6] = '{8'hFF, 8'h00, -1,  0, 65, 0,    0};
      vecs[7] = '{8'h05, 8'h00, -1,  0,  3, 0,    0};

      repeat (3) @(posedge clock);
      #1;
      check("reset_outputs", 32'(outs()), 32'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("idle_after_reset", 32'({dest_valid, busy, fifo_read_enb}), 32'd0);

      for (int v = 0; v < 8; v++) begin
         begin_run();
         dest_ready = 1'b1;
         add_pkt(vecs[v].hdr, vecs[v].corrupt, 1'b0, 0);
         if (v == 0) begin
            @(posedge clock);
            #1;
            check("latency_early", 32'(dest_valid), 32'd0);
            @(posedge clock);
            #1;
            check("latency_valid", 32'({dest_valid, dest_sop, dest_data}), 32'({1'b1, 1'b1, 8'h0D}));
         end
         drain(2000, vecs[v].stall_at, vecs[v].stall_len, 1'b0);
         end_checks($sformatf("vec%0d", v), vecs[v].exp_xfers, vecs[v].exp_err, vecs[v].exp_drop);
      end

      // back-pressure: second byte must hold steady while the client stalls
      begin_run();
      dest_ready = 1'b1;
      add_pkt(8'h0D, 8'h00, 1'b0, 0);
      seen = 0;
      for (int c = 0; c < 40 && seen == 0; c++) begin
         @(posedge clock);
         #1;
         if (dest_valid && (obs_n - base) == 1) seen = 1;
      end
      dest_ready = 1'b0;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if ({dest_valid, dest_sop, dest_eop, dest_data} !== {1'b1, 1'b0, 1'b0, 8'h11}) cnt++;
         @(posedge clock);
         #1;
      end
      check("bp_reached", seen, 1);
      check("bp_hold", cnt, 0);
      drain(2000, -1, 0, 1'b0);
      end_checks("bp", 5, 0, 0);

      // timeout: drop exactly 30 stalled cycles after valid rises
      begin_run();
      dest_ready = 1'b0;
      add_pkt(8'h0D, 8'h00, 1'b0, 0);
      for (int c = 0; c < 20 && !dest_valid; c++) begin
         @(posedge clock);
         #1;
      end
      check("to_valid_rise", 32'(dest_valid), 32'd1);
      cnt = 0;
      for (int k = 1; k < 30; k++) begin
         @(posedge clock);
         #1;
         if (pkt_drop || fifo_soft_reset || !dest_valid) cnt++;
      end
      check("to_no_early_drop", cnt, 0);
      @(posedge clock);
      #1;
      check("to_drop_cycle", 32'({pkt_drop, fifo_soft_reset, dest_valid, busy}), 32'(4'b1100));
      @(posedge clock);
      #1;
      check("to_pulse_width", 32'({pkt_drop, fifo_soft_reset}), 32'd0);
      drain(200, -1, 0, 1'b0);
      end_checks("to", 0, 0, 1);

      // asynchronous reset in the middle of the payload
      begin_run();
      dest_ready = 1'b1;
      add_pkt(8'h0D, 8'h00, 1'b0, 0);
      for (int c = 0; c < 40 && (obs_n - base) < 2; c++) begin
         @(posedge clock);
         #1;
      end
      #3;
      reset = 1'b1;
      #1;
      check("rst_async_outputs", 32'(outs()), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      begin_run();
      add_pkt(8'h04, 8'h00, 1'b0, 0);
      drain(500, -1, 0, 1'b0);
      check("rst_next_sop", 32'(obs[base][9]), 32'd1);
      end_checks("rst_after", 3, 0, 0);

      // randomized packets and client readiness
      for (int r = 0; r < 20; r++) begin
         begin_run();
         np = $urandom_range(1, 3);
         dest_ready = 1'b1;
         for (int k = 0; k < np; k++) begin
            hdr     = {6'($urandom_range(0, 12)), 2'($urandom_range(0, 3))};
            corrupt = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            add_pkt(hdr, corrupt, 1'b1, (k == 0 && (r % 5) == 0) ? 1 : 0);
         end
         drain(3000, -1, 0, 1'b1);
         end_checks($sformatf("rnd%0d", r), exp_q.size(), exp_err, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
